// File: rtl/alu4_issue_ctrl.sv
// Issue controller for the 4-bit ALU: it queues commands, drives the ALU, and returns the
// tagged result. Optional op counter: define ALU4_ISSUE_STATS_EN.
module alu4_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_option,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [2:0]       sticky_flags,
`ifdef ALU4_ISSUE_STATS_EN
    output logic [15:0]      op_count,
`endif
    input  logic             sticky_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [2:0]       op;
        logic [3:0]       a;
        logic [3:0]       b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nxt;
    cmd_t        mem [DEPTH];
    cmd_t        exec_q;
    logic [AW:0] wptr, rptr, count, count_nxt;
    logic        push, pop, empty;

    assign count = wptr - rptr;
    assign empty = (count == '0);
    assign push  = cmd_valid && cmd_ready;
    assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop       = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = EXEC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The ALU is only driven while a command is executing, so idle cycles present zeros.
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_option = '0;
        if (state == EXEC) begin
            alu_a      = exec_q.a;
            alu_b      = exec_q.b;
            alu_option = exec_q.op;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            cmd_ready <= 1'b1;
            exec_q    <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (count_nxt < FULL);
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr   <= rptr + 1'b1;
                exec_q <= mem[rptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= '0;
            rsp_flags    <= '0;
            rsp_tag      <= '0;
            sticky_flags <= '0;
        end else begin
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_carry, alu_overflow, alu_zero};
                rsp_tag    <= exec_q.tag;
            end
            // A clear in the capture cycle drops that op's flags too.
            if (sticky_clr)
                sticky_flags <= '0;
            else if (state == EXEC)
                sticky_flags <= sticky_flags | {alu_carry, alu_overflow, alu_zero};
        end
    end

`ifdef ALU4_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (sticky_clr)
            op_count <= '0;
        else if (rsp_valid && rsp_ready && op_count != 16'hFFFF)
            op_count <= op_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_alu4_issue_ctrl.sv
// Directed bench for alu4_issue_ctrl with a behavioural 4-bit ALU attached to its ALU port.
module tb_alu4_issue_ctrl;
    localparam int TAG_W = 4;

    logic             clk, rst_n;
    logic             cmd_valid, cmd_ready;
    logic [2:0]       cmd_op;
    logic [3:0]       cmd_a, cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [3:0]       alu_a, alu_b;
    logic [2:0]       alu_option;
    logic [3:0]       alu_result;
    logic             alu_carry, alu_overflow, alu_zero;
    logic             rsp_valid, rsp_ready;
    logic [3:0]       rsp_result;
    logic [2:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic [2:0]       sticky_flags;
    logic             sticky_clr;
`ifdef ALU4_ISSUE_STATS_EN
    logic [15:0]      op_count;
`endif

    alu4_issue_ctrl #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_option(alu_option),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .sticky_flags(sticky_flags),
`ifdef ALU4_ISSUE_STATS_EN
        .op_count(op_count),
`endif
        .sticky_clr(sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: b complemented with carry-in for sub/slt/eq; flags always from the adder path.
    logic       bneg;
    logic [3:0] bx, s;
    logic [4:0] sum5;
    always_comb begin
        bneg = (alu_option == 3'b001) || (alu_option == 3'b110) || (alu_option == 3'b111);
        bx   = bneg ? ~alu_b : alu_b;
        sum5 = {1'b0, alu_a} + {1'b0, bx} + {4'b0, bneg};
        s    = sum5[3:0];
        alu_carry    = sum5[4];
        alu_overflow = (alu_a[3] == bx[3]) && (s[3] != alu_a[3]);
        alu_zero     = (s == 4'h0);
        case (alu_option)
            3'b010:  alu_result = ~alu_a;
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = alu_a ^ alu_b;
            3'b110:  alu_result = {3'b0, s[3] ^ alu_overflow};
            3'b111:  alu_result = {3'b0, alu_zero};
            default: alu_result = s;
        endcase
    end

    typedef struct {
        logic [2:0]       op;
        logic [3:0]       a, b;
        logic [TAG_W-1:0] tag;
        logic [3:0]       res;
        logic [2:0]       flg;
    } vec_t;

    vec_t vecs [10];
    int   checks = 0;
    int   errors = 0;
    logic [2:0] exp_sticky;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("send_timeout", 16'd0, 16'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_timeout", 16'd0, 16'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int acc, got;
        vecs[0] = '{3'b000, 4'h7, 4'h1, 4'd3, 4'h8, 3'b010};  // add, signed overflow
        vecs[1] = '{3'b001, 4'h5, 4'h5, 4'd4, 4'h0, 3'b101};  // sub to zero
        vecs[2] = '{3'b111, 4'h5, 4'h5, 4'd5, 4'h1, 3'b101};  // eq true
        vecs[3] = '{3'b110, 4'hE, 4'h1, 4'd6, 4'h1, 3'b100};  // slt -2 < 1
        vecs[4] = '{3'b110, 4'h3, 4'hF, 4'd7, 4'h0, 3'b000};  // slt 3 < -1 false
        vecs[5] = '{3'b011, 4'hC, 4'hA, 4'd8, 4'h8, 3'b110};  // and, flags from adder
        vecs[6] = '{3'b101, 4'h3, 4'h5, 4'd9, 4'h6, 3'b010};  // xor
        vecs[7] = '{3'b010, 4'h5, 4'h0, 4'hA, 4'hA, 3'b000};  // not
        vecs[8] = '{3'b100, 4'h0, 4'h0, 4'hB, 4'h0, 3'b001};  // or, zero
        vecs[9] = '{3'b000, 4'h8, 4'h8, 4'hC, 4'h0, 3'b111};  // add, carry+overflow

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        rsp_ready = 1'b0; sticky_clr = 1'b0;
        #12;
        check("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_rsp_result", 16'(rsp_result), 16'd0);
        check("rst_rsp_flags", 16'(rsp_flags), 16'd0);
        check("rst_rsp_tag", 16'(rsp_tag), 16'd0);
        check("rst_sticky", 16'(sticky_flags), 16'd0);
        check("rst_alu", 16'({alu_a, alu_b, alu_option}), 16'd0);
        @(negedge clk) rst_n = 1'b1;

        // Single commands from idle: latency, ALU drive, captured result/flags/tag.
        exp_sticky = 3'b000;
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            @(negedge clk);
            check("lat_n1_valid", 16'(rsp_valid), 16'd0);
            check("idle_alu_zero", 16'({alu_a, alu_b, alu_option}), 16'd0);
            @(negedge clk);
            check("lat_n2_valid", 16'(rsp_valid), 16'd0);
            check("exec_alu_drive", 16'({alu_a, alu_b, alu_option}),
                  16'({vecs[i].a, vecs[i].b, vecs[i].op}));
            @(negedge clk);
            exp_sticky = exp_sticky | vecs[i].flg;
            check("rsp_valid", 16'(rsp_valid), 16'd1);
            check("rsp_result", 16'(rsp_result), 16'(vecs[i].res));
            check("rsp_flags", 16'(rsp_flags), 16'(vecs[i].flg));
            check("rsp_tag", 16'(rsp_tag), 16'(vecs[i].tag));
            check("sticky", 16'(sticky_flags), 16'(exp_sticky));
            @(negedge clk);
            check("rsp_hold", 16'({rsp_valid, rsp_result, rsp_tag}),
                  16'({1'b1, vecs[i].res, vecs[i].tag}));
            handshake();
        end
`ifdef ALU4_ISSUE_STATS_EN
        check("op_count_10", op_count, 16'd10);
`endif

        // Backpressure: DEPTH+1 accepted, then drain in order.
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = acc[3:0]; cmd_b = 4'h1;
            cmd_tag = acc[TAG_W-1:0];
            if (cmd_ready) acc++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("accepted_count", 16'(acc), 16'd5);
        @(negedge clk);
        check("full_cmd_ready", 16'(cmd_ready), 16'd0);
        check("full_rsp_head", 16'({rsp_valid, rsp_tag}), 16'({1'b1, 4'd0}));
        rsp_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 40; n++) begin
            if (rsp_valid) begin
                check("drain_tag", 16'(rsp_tag), 16'(got));
                check("drain_result", 16'(rsp_result), 16'(got + 1));
                got++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        check("drain_count", 16'(got), 16'd5);
        check("drain_cmd_ready", 16'(cmd_ready), 16'd1);

        // Sticky clear in the capture cycle beats that op's flag update.
        send(3'b000, 4'h8, 4'h8, 4'd1);
        wait_rsp();
        check("sticky_set", 16'(sticky_flags), 16'b111);
        handshake();
        send(3'b000, 4'h8, 4'h8, 4'd2);
        @(negedge clk);
        @(negedge clk);
        check("clr_exec_alu_a", 16'(alu_a), 16'h8);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        @(negedge clk);
        check("clr_rsp_flags", 16'({rsp_valid, rsp_flags}), 16'({1'b1, 3'b111}));
        check("clr_sticky", 16'(sticky_flags), 16'd0);
        handshake();
`ifdef ALU4_ISSUE_STATS_EN
        check("op_count_after_clr", op_count, 16'd1);
`endif

        // Reset while holding a response with two commands queued.
        send(3'b000, 4'h8, 4'h8, 4'd9);
        send(3'b000, 4'h8, 4'h8, 4'd10);
        send(3'b000, 4'h8, 4'h8, 4'd11);
        wait_rsp();
        check("pre_rst_rsp", 16'({rsp_valid, rsp_tag, sticky_flags}), 16'({1'b1, 4'd9, 3'b111}));
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("mid_rst_rsp_regs", 16'({rsp_result, rsp_flags, rsp_tag}), 16'd0);
        check("mid_rst_sticky", 16'(sticky_flags), 16'd0);
        check("mid_rst_cmd_ready", 16'(cmd_ready), 16'd1);
        check("mid_rst_alu", 16'({alu_a, alu_b, alu_option}), 16'd0);
        @(negedge clk) rst_n = 1'b1;
        rsp_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid) got++;
        end
        rsp_ready = 1'b0;
        check("no_replay", 16'(got), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
